// File: rtl/kbd_pkg.sv
// Shared constants and types for the memory-mapped PS/2 keyboard responder.
package kbd_pkg;

    localparam logic [3:0] KBD_REGION     = 4'he;
    localparam logic       KBD_DATA       = 1'b0;
    localparam logic       KBD_STATUS     = 1'b1;
    localparam int         PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/kbd_responder_ps2_rx.sv
// PS/2 frame receiver: pin synchronizers, falling-edge detect, frame FSM and
// mid-frame timeout. Emits one-cycle byte_valid / frame_err pulses.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    logic [1:0]      clk_sync, data_sync;
    logic            clk_prev;
    logic            fall, bit_in;
    rx_state_t       state, state_next;
    logic [2:0]      bit_cnt, bit_cnt_next;
    logic [TO_W-1:0] idle_cnt, idle_cnt_next;
    logic [7:0]      shift, shift_next;
    logic            parity, parity_next;
    logic            valid_next, err_next;

    assign fall      = clk_prev & ~clk_sync[1];
    assign bit_in    = data_sync[1];
    assign byte_data = shift;

    // Synchronizers reset high (bus idle) so releasing reset never fakes an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            idle_cnt   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_prev   <= clk_sync[1];
            state      <= state_next;
            bit_cnt    <= bit_cnt_next;
            idle_cnt   <= idle_cnt_next;
            byte_valid <= valid_next;
            frame_err  <= err_next;
        end
    end

    always_ff @(posedge clk) begin
        shift  <= shift_next;
        parity <= parity_next;
    end

    always_comb begin
        state_next    = state;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        parity_next   = parity;
        valid_next    = 1'b0;
        err_next      = 1'b0;
        idle_cnt_next = (state == RX_IDLE || fall) ? '0 : idle_cnt + TO_ONE;

        case (state)
            RX_IDLE: begin
                if (fall && !bit_in) begin
                    state_next   = RX_DATA;
                    bit_cnt_next = '0;
                end
            end
            RX_DATA: begin
                if (fall) begin
                    shift_next   = {bit_in, shift[7:1]};
                    bit_cnt_next = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_next = RX_PARITY;
                end
            end
            RX_PARITY: begin
                if (fall) begin
                    parity_next = bit_in;
                    state_next  = RX_STOP;
                end
            end
            RX_STOP: begin
                if (fall) begin
                    state_next = RX_IDLE;
                    if (bit_in && (^{shift, parity})) valid_next = 1'b1;
                    else                              err_next   = 1'b1;
                end
            end
            default: state_next = RX_IDLE;
        endcase

        if (state != RX_IDLE && !fall && idle_cnt == TO_LAST) begin
            state_next    = RX_IDLE;
            err_next      = 1'b1;
            idle_cnt_next = '0;
        end
    end

endmodule

// File: rtl/kbd_responder.sv
// PS/2 keyboard responder: scan-code FIFO with pop-on-read DATA register and
// clear-on-read STATUS register in the 4'he data-memory region.
module kbd_responder
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        dmem_read_in,
    input  logic [29:0] dmem_addr,
    output logic [31:0] kbd_data_out,
    output logic        kbd_irq
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic             byte_valid, frame_err;
    logic [7:0]       byte_data;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             overflow;
    logic [7:0]       err_cnt;
    logic             sel, sel_q, start;
    logic [29:0]      addr_q;
    logic [31:0]      resp_q, data_word, status_word, live_word;
    logic             empty, full, pop, clear, do_write;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .frame_err  (frame_err)
    );

    assign sel      = dmem_read_in & (dmem_addr[29:26] == KBD_REGION);
    assign start    = sel & ~(sel_q & (addr_q == dmem_addr));
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_CNT);
    assign pop      = start & (dmem_addr[0] == KBD_DATA) & ~empty;
    assign clear    = start & (dmem_addr[0] == KBD_STATUS);
    assign do_write = byte_valid & (~full | pop);

    assign data_word   = empty ? 32'h0 : {1'b1, 23'b0, mem[rd_ptr]};
    assign status_word = {overflow, 7'b0, err_cnt, 8'b0, 8'(count)};
    assign live_word   = (dmem_addr[0] == KBD_STATUS) ? status_word : data_word;

    // Stall cycles replay the value captured at access start, hiding the pop/clear
    assign kbd_data_out = !sel ? 32'h0 : (start ? live_word : resp_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            err_cnt  <= '0;
            sel_q    <= 1'b0;
            addr_q   <= '0;
            resp_q   <= '0;
            kbd_irq  <= 1'b0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_write, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            // A fresh event in the clearing cycle survives the clear
            if (byte_valid && full && !pop) overflow <= 1'b1;
            else if (clear)                 overflow <= 1'b0;

            if (clear)                             err_cnt <= {7'b0, frame_err};
            else if (frame_err && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;

            sel_q   <= sel;
            addr_q  <= dmem_addr;
            if (start) resp_q <= live_word;
            kbd_irq <= ~empty;
        end
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= byte_data;
    end

endmodule

// File: tb/tb_kbd_responder.sv
// Randomized bench for kbd_responder against a queue-based register model.
`timescale 1ns/1ps
module tb_kbd_responder;
    import kbd_pkg::*;

    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 600;
    localparam int HALF    = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        dmem_read_in = 1'b0;
    logic [29:0] dmem_addr = '0;
    logic [31:0] kbd_data_out;
    logic        kbd_irq;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;
    int         model_err = 0;

    kbd_responder #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .dmem_read_in (dmem_read_in),
        .dmem_addr    (dmem_addr),
        .kbd_data_out (kbd_data_out),
        .kbd_irq      (kbd_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] exp_data();
        if (model_q.size() == 0) return 32'h0;
        return {1'b1, 23'b0, model_q[0]};
    endfunction

    function automatic logic [31:0] exp_status();
        int e;
        e = (model_err > 255) ? 255 : model_err;
        return {model_ovf, 7'b0, 8'(e), 8'b0, 8'(model_q.size())};
    endfunction

    task automatic model_push(input logic [7:0] b);
        if (model_q.size() < DEPTH) model_q.push_back(b);
        else                        model_ovf = 1'b1;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input logic bad_par,
                                               input logic bad_stop);
        logic par;
        par = ~(^b) ^ bad_par;
        return {~bad_stop, par, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic [10:0] f;
        f = frame_bits(b, bad_par, bad_stop);
        for (int i = 0; i < PS2_FRAME_BITS; i++) ps2_bit(f[i]);
        tick(4);
        if (bad_par || bad_stop) model_err++;
        else                     model_push(b);
    endtask

    task automatic send_partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 1; i < nbits; i++) ps2_bit(1'($urandom));
    endtask

    // Aligns a DATA read with the cycle the received byte is pushed.
    task automatic send_frame_pop(input logic [7:0] b);
        logic [10:0] f;
        f = frame_bits(b, 1'b0, 1'b0);
        for (int i = 0; i < PS2_FRAME_BITS - 1; i++) ps2_bit(f[i]);
        ps2_data = 1'b1;
        tick(HALF);
        ps2_clk = 1'b0;
        tick(3);
        dmem_read_in = 1'b1;
        dmem_addr    = {KBD_REGION, 25'($urandom), KBD_DATA};
        #1 check("push_pop_head", kbd_data_out, exp_data());
        void'(model_q.pop_front());
        model_push(b);
        tick(1);
        dmem_read_in = 1'b0;
        tick(HALF - 4);
        ps2_clk = 1'b1;
        tick(4);
    endtask

    task automatic read_check(input string tag, input logic reg_sel, input int hold);
        logic [31:0] want;
        want = (reg_sel == KBD_STATUS) ? exp_status() : exp_data();
        @(posedge clk);
        #1;
        dmem_read_in = 1'b1;
        dmem_addr    = {KBD_REGION, 25'($urandom), reg_sel};
        for (int c = 0; c < hold; c++) begin
            if (c > 0) tick(1);
            #1 check(tag, kbd_data_out, want);
        end
        tick(1);
        dmem_read_in = 1'b0;
        if (reg_sel == KBD_STATUS) begin
            model_ovf = 1'b0;
            model_err = 0;
        end else if (model_q.size() != 0) begin
            void'(model_q.pop_front());
        end
    endtask

    task automatic foreign_read();
        logic [3:0] region;
        region = 4'($urandom_range(0, 14));
        if (region == KBD_REGION) region = 4'hf;
        tick(1);
        dmem_read_in = 1'b1;
        dmem_addr    = {region, 26'($urandom)};
        #1 check("foreign_read", kbd_data_out, 32'h0);
        tick(2);
        dmem_read_in = 1'b0;
    endtask

    task automatic check_irq(input string tag);
        tick(2);
        check(tag, {31'b0, kbd_irq}, {31'b0, model_q.size() != 0});
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check("reset_data", kbd_data_out, 32'h0);
        check("reset_irq", {31'b0, kbd_irq}, 32'h0);
        rst = 1'b1;
        tick(2);
        read_check("reset_status", KBD_STATUS, 1);

        send_frame(8'h1C, 1'b0, 1'b0);
        check_irq("irq_one");
        read_check("data_1c", KBD_DATA, 1);
        read_check("data_empty", KBD_DATA, 1);
        check_irq("irq_empty");

        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h32, 1'b0, 1'b0);
        read_check("data_hold", KBD_DATA, 5);
        read_check("status_cnt1", KBD_STATUS, 1);
        read_check("data_32", KBD_DATA, 1);

        for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom), 1'b0, 1'b0);
        read_check("status_ovf", KBD_STATUS, 2);
        read_check("status_cleared", KBD_STATUS, 1);

        send_frame_pop(8'hA5);
        read_check("status_full_pushpop", KBD_STATUS, 1);
        for (int i = 0; i < DEPTH; i++) read_check("drain", KBD_DATA, $urandom_range(1, 3));
        check_irq("irq_drained");

        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h66, 1'b0, 1'b1);
        send_partial(4);
        tick(TIMEOUT + 20);
        model_err++;
        read_check("status_err3", KBD_STATUS, 1);
        read_check("data_after_err", KBD_DATA, 1);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 5))
                0, 1: send_frame(8'($urandom), 1'b0, 1'b0);
                2: begin
                    if ($urandom_range(0, 1) == 1) send_frame(8'($urandom), 1'b1, 1'b0);
                    else                           send_frame(8'($urandom), 1'b0, 1'b1);
                end
                3: read_check($sformatf("rand_data_%0d", it), KBD_DATA, $urandom_range(1, 4));
                4: read_check($sformatf("rand_status_%0d", it), KBD_STATUS, $urandom_range(1, 4));
                default: foreign_read();
            endcase
            check_irq($sformatf("rand_irq_%0d", it));
        end

        send_partial(5);
        rst = 1'b0;
        tick(3);
        model_q.delete();
        model_ovf = 1'b0;
        model_err = 0;
        check("rst_mid_data", kbd_data_out, 32'h0);
        check("rst_mid_irq", {31'b0, kbd_irq}, 32'h0);
        rst = 1'b1;
        tick(2);
        send_frame(8'hF0, 1'b0, 1'b0);
        read_check("data_f0", KBD_DATA, 1);
        read_check("status_after_rst", KBD_STATUS, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
